// File: rtl/slc3_mem_responder.sv
// rtl/slc3_mem_responder.sv - SLC-3 memory-side responder: cleared word array, pipelined reads, loader port
module slc3_mem_responder #(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] ADDR,
    input  logic        OE,
    input  logic        WE,
    input  logic [15:0] Data_to_SRAM,
    output logic [15:0] Data_from_SRAM,
    output logic        rd_valid,
    output logic        mem_ready,
    input  logic        ld_valid,
    input  logic [15:0] ld_addr,
    input  logic [15:0] ld_data,
    output logic        ld_ready
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_INIT,
        ST_ACTIVE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;

    logic [15:0]         mem [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [15:0]         mem_wdata;

    logic [ADDR_W-1:0]   cpu_addr;
    logic [ADDR_W-1:0]   ldr_addr;
    logic                rd_issue;
    logic [15:0]         rd_word;

    logic                s1_valid_q, s1_valid_d;
    logic [15:0]         s1_data_q, s1_data_d;

    logic                unused_addr_bits;

    assign cpu_addr         = ADDR[ADDR_W-1:0];
    assign ldr_addr         = ld_addr[ADDR_W-1:0];
    assign unused_addr_bits = ^{ADDR[15:ADDR_W], ld_addr[15:ADDR_W]};

    // Combinational read gives read-before-write: the edge that stores a
    // new word also captures the old one into the pipeline.
    assign rd_word = mem[cpu_addr];

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_we    = 1'b0;
        mem_waddr = cpu_addr;
        mem_wdata = Data_to_SRAM;
        rd_issue  = 1'b0;
        mem_ready = 1'b0;
        ld_ready  = 1'b0;

        case (state_q)
            ST_INIT: begin
                mem_we    = !Reset;
                mem_waddr = clr_cnt_q;
                mem_wdata = 16'h0000;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                mem_ready = 1'b1;
                ld_ready  = !WE;
                rd_issue  = OE;
                if (WE) begin
                    mem_we = 1'b1;
                end else if (ld_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = ldr_addr;
                    mem_wdata = ld_data;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_comb begin
        s1_valid_d = rd_issue;
        s1_data_d  = s1_data_q;
        if (rd_issue) begin
            s1_data_d = rd_word;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_INIT;
            clr_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= 16'h0000;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    generate
        if (READ_LAT >= 2) begin : g_lat2
            logic        s2_valid_q, s2_valid_d;
            logic [15:0] s2_data_q, s2_data_d;

            always_comb begin
                s2_valid_d = s1_valid_q;
                s2_data_d  = s2_data_q;
                if (s1_valid_q) begin
                    s2_data_d = s1_data_q;
                end
            end

            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    s2_valid_q <= 1'b0;
                    s2_data_q  <= 16'h0000;
                end else begin
                    s2_valid_q <= s2_valid_d;
                    s2_data_q  <= s2_data_d;
                end
            end

            assign rd_valid       = s2_valid_q;
            assign Data_from_SRAM = s2_data_q;
        end else begin : g_lat1
            assign rd_valid       = s1_valid_q;
            assign Data_from_SRAM = s1_data_q;
        end
    endgenerate

endmodule

// File: tb/tb_slc3_mem_responder.sv
// tb/tb_slc3_mem_responder.sv - randomized and directed bench against a behavioural memory model
module tb_slc3_mem_responder;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] ADDR = 16'h0;
    logic        OE = 1'b0;
    logic        WE = 1'b0;
    logic [15:0] Data_to_SRAM = 16'h0;
    logic        ld_valid = 1'b0;
    logic [15:0] ld_addr = 16'h0;
    logic [15:0] ld_data = 16'h0;

    logic [15:0] dout_a, dout_b;
    logic        rv_a, rv_b, mr_a, mr_b, lr_a, lr_b;

    always #5 Clk = ~Clk;

    // Instance a: 16 words, latency 1. Instance b: 1024 words, latency 2.
    slc3_mem_responder #(.ADDR_W(4), .READ_LAT(1)) dut_a (
        .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .OE(OE), .WE(WE),
        .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(dout_a), .rd_valid(rv_a),
        .mem_ready(mr_a), .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_ready(lr_a)
    );

    slc3_mem_responder #(.ADDR_W(10), .READ_LAT(2)) dut_b (
        .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .OE(OE), .WE(WE),
        .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(dout_b), .rd_valid(rv_b),
        .mem_ready(mr_b), .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_ready(lr_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: word array, cycles since reset, read result history.
    logic [15:0] mm [2][1024];
    int          cyc [2] = '{0, 0};
    logic        h0v [2] = '{1'b0, 1'b0};
    logic        h1v [2] = '{1'b0, 1'b0};
    logic [15:0] h0d [2] = '{16'h0, 16'h0};
    logic [15:0] h1d [2] = '{16'h0, 16'h0};
    logic        ev  [2] = '{1'b0, 1'b0};
    logic [15:0] ed  [2] = '{16'h0, 16'h0};
    int          dep_m, lat_m, a_m, la_m;
    logic        nv_m;
    logic [15:0] nd_m;

    always @(posedge Clk or posedge Reset) begin
        for (int k = 0; k < 2; k++) begin
            dep_m = (k == 0) ? 16 : 1024;
            lat_m = (k == 0) ? 1 : 2;
            if (Reset) begin
                cyc[k] = 0;
                h0v[k] = 1'b0; h1v[k] = 1'b0;
                h0d[k] = 16'h0; h1d[k] = 16'h0;
                ev[k]  = 1'b0; ed[k] = 16'h0;
            end else begin
                nv_m = 1'b0;
                nd_m = 16'h0;
                if (cyc[k] < dep_m) begin
                    mm[k][cyc[k]] = 16'h0;
                    cyc[k]++;
                end else begin
                    a_m  = int'(ADDR) % dep_m;
                    la_m = int'(ld_addr) % dep_m;
                    if (OE) begin
                        nv_m = 1'b1;
                        nd_m = mm[k][a_m];
                    end
                    if (WE) mm[k][a_m] = Data_to_SRAM;
                    else if (ld_valid) mm[k][la_m] = ld_data;
                end
                h1v[k] = h0v[k]; h1d[k] = h0d[k];
                h0v[k] = nv_m;   h0d[k] = nd_m;
                ev[k] = (lat_m == 1) ? h0v[k] : h1v[k];
                if (ev[k]) ed[k] = (lat_m == 1) ? h0d[k] : h1d[k];
            end
        end
    end

    function automatic logic exp_ready(input int k);
        return !Reset && (cyc[k] >= ((k == 0) ? 16 : 1024));
    endfunction

    always @(negedge Clk) begin
        #2;
        chk("mem_ready_a", 16'(mr_a), 16'(exp_ready(0)));
        chk("mem_ready_b", 16'(mr_b), 16'(exp_ready(1)));
        chk("ld_ready_a", 16'(lr_a), 16'(exp_ready(0) && !WE));
        chk("ld_ready_b", 16'(lr_b), 16'(exp_ready(1) && !WE));
        chk("rd_valid_a", 16'(rv_a), 16'(ev[0]));
        chk("rd_valid_b", 16'(rv_b), 16'(ev[1]));
        chk("data_a", dout_a, ed[0]);
        chk("data_b", dout_b, ed[1]);
    end

    task automatic cyc_drive(input logic oe, input logic we, input logic [15:0] addr,
                             input logic [15:0] data, input logic lv,
                             input logic [15:0] la, input logic [15:0] ldd);
        @(negedge Clk);
        OE = oe; WE = we; ADDR = addr; Data_to_SRAM = data;
        ld_valid = lv; ld_addr = la; ld_data = ldd;
        #1;
    endtask

    task automatic idle();
        cyc_drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic rd(input logic [15:0] addr, input logic [15:0] expv);
        cyc_drive(1'b1, 1'b0, addr, 16'h0, 1'b0, 16'h0, 16'h0);
        idle();
        chk("rd_lit_valid_a", 16'(rv_a), 16'h1);
        chk("rd_lit_data_a", dout_a, expv);
        idle();
        chk("rd_lit_valid_a_off", 16'(rv_a), 16'h0);
        chk("rd_lit_valid_b", 16'(rv_b), 16'h1);
        chk("rd_lit_data_b", dout_b, expv);
    endtask

    // Call at the negedge where Reset has just been released.
    task automatic check_init();
        repeat (15) @(posedge Clk);
        #1 chk("init_a_15", 16'(mr_a), 16'h0);
        @(posedge Clk);
        #1 chk("init_a_16", 16'(mr_a), 16'h1);
        chk("init_a_ldr", 16'(lr_a), 16'(!WE));
        repeat (1024 - 17) @(posedge Clk);
        #1 chk("init_b_1023", 16'(mr_b), 16'h0);
        @(posedge Clk);
        #1 chk("init_b_1024", 16'(mr_b), 16'h1);
    endtask

    initial begin
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        #1 chk("rst_data_a", dout_a, 16'h0);
        chk("rst_ready_b", 16'(mr_b), 16'h0);
        Reset = 1'b0;
        check_init();

        for (int i = 0; i < 16; i++) cyc_drive(1'b1, 1'b0, 16'(i), 16'h0, 1'b0, 16'h0, 16'h0);
        idle();
        chk("clear_last_a", dout_a, 16'h0);
        idle();

        cyc_drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0003, 16'h1234);
        chk("ldr_acc_a", 16'(lr_a), 16'h1);
        chk("ldr_acc_b", 16'(lr_b), 16'h1);
        idle();
        rd(16'h0003, 16'h1234);

        cyc_drive(1'b0, 1'b1, 16'h0005, 16'hBEEF, 1'b1, 16'h0006, 16'h6666);
        chk("ldr_stall_a", 16'(lr_a), 16'h0);
        chk("ldr_stall_b", 16'(lr_b), 16'h0);
        cyc_drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0006, 16'h6666);
        chk("ldr_retry_a", 16'(lr_a), 16'h1);
        idle();
        rd(16'h0005, 16'hBEEF);
        rd(16'h0006, 16'h6666);

        cyc_drive(1'b0, 1'b1, 16'h0002, 16'hAAAA, 1'b0, 16'h0, 16'h0);
        cyc_drive(1'b1, 1'b1, 16'h0002, 16'h5555, 1'b0, 16'h0, 16'h0);
        idle();
        chk("rbw_a", dout_a, 16'hAAAA);
        idle();
        chk("rbw_b", dout_b, 16'hAAAA);
        rd(16'h0002, 16'h5555);

        for (int i = 0; i < 4; i++) cyc_drive(1'b0, 1'b1, 16'(i), 16'(16'h10 + i), 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 7; i++) begin
            cyc_drive(i < 4, 1'b0, 16'(i), 16'h0, 1'b0, 16'h0, 16'h0);
            chk("burst_valid_a", 16'(rv_a), 16'(i >= 1 && i <= 4));
            chk("burst_valid_b", 16'(rv_b), 16'(i >= 2 && i <= 5));
            if (i >= 2 && i <= 5) chk("burst_data_b", dout_b, 16'(16'h10 + i - 2));
        end

        rd(16'h0401, 16'h0011);

        for (int n = 0; n < 400; n++) begin
            @(negedge Clk);
            if (!(ld_valid && WE)) begin
                ld_valid = ($urandom_range(0, 2) == 0);
                ld_addr  = 16'($urandom);
                ld_data  = 16'($urandom);
            end
            OE = 1'($urandom_range(0, 1));
            WE = ($urandom_range(0, 2) == 0);
            ADDR = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            Data_to_SRAM = 16'($urandom);
        end
        repeat (3) idle();

        cyc_drive(1'b0, 1'b1, 16'h0009, 16'h9999, 1'b0, 16'h0, 16'h0);
        cyc_drive(1'b1, 1'b0, 16'h0009, 16'h0, 1'b0, 16'h0, 16'h0);
        cyc_drive(1'b1, 1'b0, 16'h0009, 16'h0, 1'b0, 16'h0, 16'h0);
        chk("pre_rst_data_a", dout_a, 16'h9999);
        Reset = 1'b1;
        #1 chk("midrd_data_a", dout_a, 16'h0);
        chk("midrd_valid_a", 16'(rv_a), 16'h0);
        chk("midrd_ready_a", 16'(mr_a), 16'h0);
        chk("midrd_ldr_b", 16'(lr_b), 16'h0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (7) @(posedge Clk);
        #1 Reset = 1'b1;
        #1 chk("midinit_ready_a", 16'(mr_a), 16'h0);
        chk("midinit_valid_b", 16'(rv_b), 16'h0);
        chk("midinit_data_b", dout_b, 16'h0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        OE = 1'b0;
        check_init();
        rd(16'h0009, 16'h0000);
        repeat (2) idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/slc3_mem_responder.md
Name: slc3_mem_responder

Overview:
Memory-side responder for the SLC-3 core's memory interface. Serves the CPU's ADDR/OE/WE/Data_to_SRAM requests from an on-chip 16-bit word array and returns read data on Data_from_SRAM with a fixed, parameterised latency. After every reset it clears the whole array. It also accepts program words from an external loader through a valid/ready port.

Parameters:
ADDR_W, 10, number of address bits used to index the array; DEPTH = 2**ADDR_W words.
READ_LAT, 1, cycles from the edge that samples OE until Data_from_SRAM/rd_valid update; legal values 1 or 2.

Ports:
Clk  input  1  system clock; all state updates on the rising edge.
Reset  input  1  asynchronous, active-high reset.
ADDR  input  16  word address from CPU MAR; only ADDR[ADDR_W-1:0] is used.
OE  input  1  active-high read request, sampled each cycle.
WE  input  1  active-high write request, sampled each cycle.
Data_to_SRAM  input  16  CPU write data.
Data_from_SRAM  output  16  registered read data; holds its last value.
rd_valid  output  1  one-cycle pulse when Data_from_SRAM carries a newly read word.
mem_ready  output  1  high when in ACTIVE state.
ld_valid  input  1  loader write request.
ld_addr  input  16  loader address; only the low ADDR_W bits are used.
ld_data  input  16  loader write data.
ld_ready  output  1  loader request accepted this cycle when ld_valid && ld_ready.

Behaviour:
- Reset, applied asynchronously at any time including mid-clear or mid-read:
  - state=INIT, clear counter=0, read pipeline valid bits cleared.
  - Data_from_SRAM=0, rd_valid=0, mem_ready=0, ld_ready=0.
- States: INIT and ACTIVE.
- INIT:
  - Each cycle writes 0 to mem[counter], then counter++.
  - When counter reaches DEPTH-1 and that word is written, the state moves to ACTIVE next cycle. INIT therefore lasts exactly DEPTH cycles after reset release.
  - OE, WE and ld_valid are ignored: no read is issued, no write happens, ld_ready=0.
- ACTIVE:
  - mem_ready=1.
  - ld_ready = !WE (combinational).
- Write (ACTIVE, WE=1): mem[ADDR[ADDR_W-1:0]] <= Data_to_SRAM at the edge.
- Loader write (ACTIVE, ld_valid && ld_ready): mem[ld_addr[ADDR_W-1:0]] <= ld_data.
  - A CPU write always wins: when WE=1 the loader is stalled and must hold ld_* stable.
- Read (ACTIVE, OE=1): the array is read at the sampling edge with read-before-write semantics.
  - If WE=1 in the same cycle, the returned word is the OLD contents and the new word is stored.
  - READ_LAT=1: Data_from_SRAM and rd_valid update at that same edge.
  - READ_LAT=2: a second register stage delays both by one more cycle.
- Back-to-back reads: OE held high for N cycles with changing ADDR yields N consecutive rd_valid pulses (fully pipelined). Each data word corresponds to the ADDR of its issuing cycle.
- rd_valid=0 in any output cycle with no issued read; Data_from_SRAM holds its value.
- Address wrap: ADDR bits at and above ADDR_W are ignored. Example with ADDR_W=10: address 0x0400 aliases to 0x0000.
- Loader requests pending at reset are dropped; the loader must re-present after mem_ready rises.
- No X on any output after reset; the memory contents are fully defined after INIT.

Test Plan:
- Reset release, ADDR_W=4 -> mem_ready rises exactly 16 cycles later; an OE read of every address returns 0x0000 with rd_valid pulses.
- Loader writes 0x1234 to ld_addr=0x0003 while WE=0 -> ld_ready=1, accepted. A later OE read at ADDR=0x0003 returns 0x1234 after READ_LAT cycles.
- Same cycle: WE=1 to address 5 with data 0xBEEF, ld_valid=1 to address 6 -> ld_ready=0, address 5=0xBEEF. The loader write lands the next cycle with WE=0; reads return 0xBEEF and the loader data.
- mem[2]=0xAAAA; assert OE=1 and WE=1 at ADDR=2 with Data_to_SRAM=0x5555 -> returned data is 0xAAAA; the next read of address 2 returns 0x5555.
- READ_LAT=2, OE held 4 cycles on ADDR 0,1,2,3 preloaded with 0x10,0x11,0x12,0x13 -> rd_valid high for 4 consecutive cycles starting 2 cycles later, with data 0x10..0x13 in order. With ADDR_W=10, ADDR=0x0401 returns the contents of 0x0001.
- Assert Reset mid-INIT (counter=7) and again mid-read -> all outputs go to 0 immediately (asynchronously). After release INIT restarts from 0 and takes the full DEPTH cycles; no stale rd_valid appears.
